// File: rtl/alu_seq_div.sv
// alu_seq_div: sequential 32-bit restoring divider with an IDLE/RUN/DONE FSM.
// One shift-subtract step per RUN cycle (32 steps). A zero divisor skips RUN
// and goes straight to DONE.
// Optional feature macro: ALU_DIV_SIGNED_EN selects two's-complement operands,
// handled by dividing magnitudes and fixing the signs in DONE.
module alu_seq_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

`ifdef ALU_DIV_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [5:0]  r_count;
  logic [31:0] r_quo;       // dividend bits shift out, quotient bits shift in
  logic [31:0] r_rem;       // partial remainder
  logic [31:0] r_divisor;
  logic [31:0] r_a_orig;    // original dividend, returned on divide by zero
  logic        r_dz;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        r_busy;
  logic        r_done;
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;
  logic        r_div_zero;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_shift;
  logic [31:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  function automatic logic [31:0] f_neg(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  // Operand signs and magnitudes (signs are always zero in the unsigned build)
  always_comb begin
    w_a_neg = SIGNED_EN & a[31];
    w_b_neg = SIGNED_EN & b[31];
    if (w_a_neg) w_a_mag = f_neg(a);
    else         w_a_mag = a;
    if (w_b_neg) w_b_mag = f_neg(b);
    else         w_b_mag = b;
  end

  // One restoring step: 33-bit shifted remainder compared against the divisor.
  // Only the low 32 bits of the difference are kept since a kept result is
  // always smaller than the divisor.
  always_comb begin
    w_shift = {r_rem, r_quo[31]};
    w_ge    = (w_shift >= {1'b0, r_divisor});
    w_diff  = w_shift[31:0] - r_divisor;
    if (w_ge) w_rem_nxt = w_diff;
    else      w_rem_nxt = w_shift[31:0];
  end

  // Sign correction applied to the magnitude result in DONE
  always_comb begin
    if (r_neg_q) w_q_fix = f_neg(r_quo);
    else         w_q_fix = r_quo;
    if (r_neg_r) w_r_fix = f_neg(r_rem);
    else         w_r_fix = r_rem;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (b == 32'd0) w_state_nxt = S_DONE;
          else            w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_count == 6'd31) w_state_nxt = S_DONE;
        else                  w_state_nxt = S_RUN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and iterative datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= 6'd0;
      r_quo     <= 32'd0;
      r_rem     <= 32'd0;
      r_divisor <= 32'd0;
      r_a_orig  <= 32'd0;
      r_dz      <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count   <= 6'd0;
            r_quo     <= w_a_mag;
            r_rem     <= 32'd0;
            r_divisor <= w_b_mag;
            r_a_orig  <= a;
            r_dz      <= (b == 32'd0);
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
          end
        end
        S_RUN: begin
          r_quo   <= {r_quo[30:0], w_ge};
          r_rem   <= w_rem_nxt;
          r_count <= r_count + 6'd1;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  // Registered outputs: busy follows the next state, results load in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= 32'd0;
      r_remainder <= 32'd0;
      r_div_zero  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        if (r_dz) begin
          r_quotient  <= 32'hFFFF_FFFF;
          r_remainder <= r_a_orig;
          r_div_zero  <= 1'b1;
        end else begin
          r_quotient  <= w_q_fix;
          r_remainder <= w_r_fix;
          r_div_zero  <= 1'b0;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_alu_seq_div.sv
// Testbench for alu_seq_div: cycle-level behavioural model (countdown to the
// done pulse, results from plain / and %) compared on every falling edge,
// plus directed literal cases and randomized traffic.
module tb_alu_seq_div;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq_div dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic
  function automatic logic [31:0] ref_q(input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    if (y == 32'd0) return 32'hFFFF_FFFF;
`ifdef ALU_DIV_SIGNED_EN
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
    sx = x; sy = y;
    return sx / sy;
`else
    sx = 0; sy = 0;
    return x / y + sx + sy;
`endif
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    if (y == 32'd0) return x;
`ifdef ALU_DIV_SIGNED_EN
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
    sx = x; sy = y;
    return sx % sy;
`else
    sx = 0; sy = 0;
    return x % y + sx + sy;
`endif
  endfunction

  // Behavioural model: count edges from acceptance to the done pulse
  logic        m_busy, m_done, m_dz, p_dz;
  logic [31:0] m_q, m_r, p_q, p_r;
  int          m_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_q <= 32'd0; m_r <= 32'd0; m_left <= 0;
      p_q <= 32'd0; p_r <= 32'd0; p_dz <= 1'b0;
    end else if (m_left == 0) begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_left <= (b == 32'd0) ? 1 : 33;
        p_q    <= ref_q(a, b);
        p_r    <= ref_r(a, b);
        p_dz   <= (b == 32'd0);
      end else begin
        m_busy <= 1'b0;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_q    <= p_q;
        m_r    <= p_r;
        m_dz   <= p_dz;
      end
    end
  end

  // Compare DUT against the model every cycle outside reset
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("model_done", {31'd0, done}, {31'd0, m_done});
      chk("model_quotient", quotient, m_q);
      chk("model_remainder", remainder, m_r);
      chk("model_div_zero", {31'd0, div_zero}, {31'd0, m_dz});
    end
  end

  // Directed division with literal expectations, latency and busy length
  task automatic do_div(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int elat, input int inj,
                        input string nm);
    int cnt, bcnt;
    bit got;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cnt = 1; bcnt = 0; got = 1'b0;
    while (!got && cnt <= 40) begin
      if (busy) bcnt++;
      if (done) got = 1'b1;
      else begin
        if (inj != 0 && cnt == inj) begin
          start = 1'b1; a = 32'd9; b = 32'd3;
        end else start = 1'b0;
        @(negedge clk);
        cnt++;
      end
    end
    start = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL %s_timeout: no done within 40 cycles", nm);
    end else begin
      chk({nm, "_latency"}, cnt, elat);
      chk({nm, "_busy_cycles"}, bcnt, elat - 1);
      chk({nm, "_q"}, quotient, eq);
      chk({nm, "_r"}, remainder, er);
      chk({nm, "_dz"}, {31'd0, div_zero}, {31'd0, edz});
    end
  endtask

  initial begin
    int extra;
    int sel;
    reset = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    chk("reset_dz", {31'd0, div_zero}, 32'd0);
    reset = 1'b0;

    do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0, "d100_7");
    do_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 0, "dmax_1");
    do_div(32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 2, 0, "d55_0");
    do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 10, "d_ignore");
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("no_extra_done", extra, 0);

    // Reset in the middle of a run
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_q", quotient, 32'd0);
    chk("midrst_r", remainder, 32'd0);
    chk("midrst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_div(32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 34, 0, "d20_6");
`ifdef ALU_DIV_SIGNED_EN
    do_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0, "dneg7_2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 0, "dovf");
`endif

    // Randomized traffic, including starts while busy and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      a = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel < 4)  b = $urandom_range(1, 15);
      else if (sel == 4) begin b = 32'hFFFF_FFFF; a = 32'h8000_0000; end
      else               b = $urandom;
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
